// File: rtl/dds_cfg_pkg.sv
// Shared constants and types for the DDS sweep sequencer:
// RING_DDS register map, the control word written at sweep start,
// and the sequencer state encoding.
package dds_cfg_pkg;

    localparam logic [15:0] DDS_ADDR_CTRL = 16'h0030;
    localparam logic [15:0] DDS_ADDR_FREQ = 16'h0020;
    localparam logic [15:0] DDS_CTRL_VAL  = 16'h000F;
    localparam int          DDS_STEP_W    = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_CTRL = 3'd1,
        GAP     = 3'd2,
        WR_FREQ = 3'd3,
        DWELL   = 3'd4
    } dds_state_t;

    // A dwell of 0 still needs one cycle between writes so that
    // wr never stays high on two consecutive cycles.
    function automatic logic [15:0] clamp_dwell(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/dds_reg_wr_if.sv
// Registered RING_DDS write port. A one-cycle request becomes a
// one-cycle wr strobe with address/data; with no request the whole
// bus is driven to zero.
module dds_reg_wr_if (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_data,
    output logic        wr,
    output logic [15:0] waddr,
    output logic [15:0] wdata
);

    // Capture a request for exactly one cycle, otherwise park the bus at zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr    <= 1'b0;
            waddr <= 16'd0;
            wdata <= 16'd0;
        end else if (req) begin
            wr    <= 1'b1;
            waddr <= req_addr;
            wdata <= req_data;
        end else begin
            wr    <= 1'b0;
            waddr <= 16'd0;
            wdata <= 16'd0;
        end
    end

endmodule

// File: rtl/dds_sweep_sequencer.sv
// Frequency sweep sequencer for RING_DDS. On start it writes the
// control register once, then steps the frequency word from a start
// value by a fixed increment, holding each step for a dwell period.
// Handshake: start/stop are single-cycle pulses sampled on the rising
// clock edge; start is honoured only in IDLE and stop always wins.
// The write port has no backpressure: each wr cycle is one accepted write.
module dds_sweep_sequencer
    import dds_cfg_pkg::*;
#(
    parameter logic [15:0] ADDR_CTRL = DDS_ADDR_CTRL,
    parameter logic [15:0] ADDR_FREQ = DDS_ADDR_FREQ,
    parameter logic [15:0] CTRL_VAL  = DDS_CTRL_VAL,
    parameter int          STEP_W    = DDS_STEP_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              stop,
    input  logic [15:0]       start_word,
    input  logic [15:0]       step_word,
    input  logic [STEP_W-1:0] num_steps,
    input  logic [15:0]       dwell,
    input  logic              loop_en,
    output logic              wr,
    output logic [15:0]       waddr,
    output logic [15:0]       wdata,
    output logic              busy,
    output logic [STEP_W-1:0] step_idx,
    output logic              done,
    output dds_state_t        state_dbg
);

    localparam logic [STEP_W-1:0] IDX_ONE = {{(STEP_W-1){1'b0}}, 1'b1};

    dds_state_t        state;
    dds_state_t        nxt_state;
    logic [15:0]       cur;
    logic [15:0]       nxt_cur;
    logic [STEP_W-1:0] idx;
    logic [STEP_W-1:0] nxt_idx;
    logic [15:0]       dcnt;

    // Configuration captured at start; inputs are ignored while busy.
    logic [15:0]       start_l;
    logic [15:0]       step_l;
    logic [STEP_W-1:0] num_l;
    logic [15:0]       dwell_l;
    logic              loop_l;

    logic              req_ctrl;
    logic              req_freq;
    logic              done_nxt;
    logic              last_step;
    logic [15:0]       req_addr;
    logic [15:0]       req_data;

    assign last_step = (idx == (num_l - IDX_ONE));
    assign state_dbg = state;

    // Next-state decode; write requests are raised on the transition
    // into a write state so the registered bus lines up with that state.
    always_comb begin
        nxt_state = state;
        nxt_cur   = cur;
        nxt_idx   = idx;
        req_ctrl  = 1'b0;
        req_freq  = 1'b0;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    nxt_state = WR_CTRL;
                    req_ctrl  = 1'b1;
                    nxt_cur   = start_word;
                    nxt_idx   = '0;
                end
            end
            WR_CTRL: nxt_state = GAP;
            GAP: begin
                if (num_l == '0) begin
                    nxt_state = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    nxt_state = WR_FREQ;
                    req_freq  = 1'b1;
                end
            end
            WR_FREQ: nxt_state = DWELL;
            DWELL: begin
                if (dcnt == 16'd1) begin
                    if (last_step && loop_l) begin
                        nxt_state = WR_FREQ;
                        req_freq  = 1'b1;
                        nxt_cur   = start_l;
                        nxt_idx   = '0;
                    end else if (last_step) begin
                        nxt_state = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        nxt_state = WR_FREQ;
                        req_freq  = 1'b1;
                        nxt_cur   = cur + step_l;
                        nxt_idx   = idx + IDX_ONE;
                    end
                end
            end
            default: nxt_state = IDLE;
        endcase
        // stop overrides everything, including a same-cycle start in IDLE
        if (stop) begin
            nxt_state = IDLE;
            nxt_cur   = cur;
            nxt_idx   = idx;
            req_ctrl  = 1'b0;
            req_freq  = 1'b0;
            done_nxt  = 1'b0;
        end
    end

    // Sequencer state, counters, latched configuration and registered status.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            cur      <= 16'd0;
            idx      <= '0;
            dcnt     <= 16'd0;
            start_l  <= 16'd0;
            step_l   <= 16'd0;
            num_l    <= '0;
            dwell_l  <= 16'd0;
            loop_l   <= 1'b0;
            step_idx <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state <= nxt_state;
            cur   <= nxt_cur;
            idx   <= nxt_idx;
            done  <= done_nxt;
            busy  <= (nxt_state != IDLE);
            if (req_ctrl) begin
                start_l <= start_word;
                step_l  <= step_word;
                num_l   <= num_steps;
                dwell_l <= dwell;
                loop_l  <= loop_en;
            end
            if (req_freq) begin
                step_idx <= nxt_idx;
            end
            if (state == WR_FREQ) begin
                dcnt <= clamp_dwell(dwell_l);
            end else if (state == DWELL) begin
                dcnt <= dcnt - 16'd1;
            end
        end
    end

    assign req_addr = req_ctrl ? ADDR_CTRL : ADDR_FREQ;
    assign req_data = req_ctrl ? CTRL_VAL  : nxt_cur;

    dds_reg_wr_if u_wr_if (
        .clk      (clk),
        .rstn     (rstn),
        .req      (req_ctrl | req_freq),
        .req_addr (req_addr),
        .req_data (req_data),
        .wr       (wr),
        .waddr    (waddr),
        .wdata    (wdata)
    );

endmodule

// File: tb/tb_dds_sweep_sequencer.sv
// Directed bench for dds_sweep_sequencer: each write and done pulse is
// logged with its cycle number and compared against hand-derived values.
module tb_dds_sweep_sequencer;
    import dds_cfg_pkg::*;

    logic        clk;
    logic        rstn;
    logic        start;
    logic        stop;
    logic [15:0] start_word;
    logic [15:0] step_word;
    logic [7:0]  num_steps;
    logic [15:0] dwell;
    logic        loop_en;
    logic        wr;
    logic [15:0] waddr;
    logic [15:0] wdata;
    logic        busy;
    logic [7:0]  step_idx;
    logic        done;
    dds_state_t  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int s;
    logic prev_wr = 1'b0;

    logic [15:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    int          wr_cyc_q[$];
    int          done_cyc_q[$];
    logic        done_busy_q[$];

    dds_sweep_sequencer dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .stop       (stop),
        .start_word (start_word),
        .step_word  (step_word),
        .num_steps  (num_steps),
        .dwell      (dwell),
        .loop_en    (loop_en),
        .wr         (wr),
        .waddr      (waddr),
        .wdata      (wdata),
        .busy       (busy),
        .step_idx   (step_idx),
        .done       (done),
        .state_dbg  (state_dbg)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // bus monitor: logs writes and done pulses, checks bus invariants
    always @(negedge clk) begin
        n_checks++;
        assert (!(wr === 1'b1 && prev_wr === 1'b1)) else begin
            n_fail++;
            $error("FAIL wr_b2b: wr high two cycles running at cycle %0d, required a gap", cyc);
        end
        if (wr !== 1'b1) begin
            n_checks++;
            assert (waddr === 16'd0 && wdata === 16'd0) else begin
                n_fail++;
                $error("FAIL bus_idle: waddr=%h wdata=%h at cycle %0d, required 0/0", waddr, wdata, cyc);
            end
        end
        if (wr === 1'b1) begin
            wr_addr_q.push_back(waddr);
            wr_data_q.push_back(wdata);
            wr_cyc_q.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cyc_q.push_back(cyc);
            done_busy_q.push_back(busy);
        end
        prev_wr = wr;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h, required %h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        done_cyc_q.delete();
        done_busy_q.delete();
    endtask

    task automatic set_cfg(input logic [15:0] sw, input logic [15:0] stw,
                           input logic [7:0] n, input logic [15:0] dw, input logic lp);
        start_word = sw;
        step_word  = stw;
        num_steps  = n;
        dwell      = dw;
        loop_en    = lp;
    endtask

    // driver: start sampled on the edge after the current negedge
    task automatic pulse_start(output int s_out);
        @(negedge clk);
        start = 1'b1;
        s_out = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    initial begin
        rstn  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        set_cfg(16'h0, 16'h0, 8'd0, 16'd0, 1'b0);
        repeat (3) @(negedge clk);

        // reset state
        check("rst_wr", wr, 0);
        check("rst_waddr", waddr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_step_idx", step_idx, 0);
        check("rst_done", done, 0);
        check("rst_state", state_dbg, IDLE);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // basic sweep: 2,3,4 with dwell 4
        clear_logs();
        set_cfg(16'h0002, 16'h0001, 8'd3, 16'd4, 1'b0);
        pulse_start(s);
        check("t1_ctrl_wr", wr, 1);
        check("t1_ctrl_busy", busy, 1);
        check("t1_ctrl_state", state_dbg, WR_CTRL);
        repeat (24) @(negedge clk);
        check("t1_nwr", wr_addr_q.size(), 4);
        check("t1_a0", wr_addr_q[0], 16'h0030);
        check("t1_d0", wr_data_q[0], 16'h000F);
        check("t1_a1", wr_addr_q[1], 16'h0020);
        check("t1_d1", wr_data_q[1], 16'h0002);
        check("t1_d2", wr_data_q[2], 16'h0003);
        check("t1_a3", wr_addr_q[3], 16'h0020);
        check("t1_d3", wr_data_q[3], 16'h0004);
        check("t1_c0", wr_cyc_q[0], s + 1);
        check("t1_c1", wr_cyc_q[1], s + 3);
        check("t1_sp12", wr_cyc_q[2] - wr_cyc_q[1], 5);
        check("t1_sp23", wr_cyc_q[3] - wr_cyc_q[2], 5);
        check("t1_ndone", done_cyc_q.size(), 1);
        check("t1_done_cyc", done_cyc_q[0], s + 18);
        check("t1_done_busy", done_busy_q[0], 0);
        check("t1_step_idx", step_idx, 2);
        check("t1_busy_end", busy, 0);

        // wrap-around with dwell clamped to 1
        clear_logs();
        set_cfg(16'hFFFE, 16'h0003, 8'd2, 16'd0, 1'b0);
        pulse_start(s);
        repeat (10) @(negedge clk);
        check("t2_nwr", wr_addr_q.size(), 3);
        check("t2_d1", wr_data_q[1], 16'hFFFE);
        check("t2_d2", wr_data_q[2], 16'h0001);
        check("t2_sp", wr_cyc_q[2] - wr_cyc_q[1], 2);
        check("t2_ndone", done_cyc_q.size(), 1);
        check("t2_done_cyc", done_cyc_q[0], s + 7);

        // looping sweep, stopped in DWELL
        clear_logs();
        set_cfg(16'h0010, 16'h0010, 8'd2, 16'd2, 1'b1);
        pulse_start(s);
        repeat (12) @(negedge clk);
        check("t3_state_dwell", state_dbg, DWELL);
        pulse_stop();
        check("t3_wr_after_stop", wr, 0);
        check("t3_busy_after_stop", busy, 0);
        check("t3_state_after_stop", state_dbg, IDLE);
        repeat (8) @(negedge clk);
        check("t3_nwr", wr_addr_q.size(), 5);
        check("t3_d1", wr_data_q[1], 16'h0010);
        check("t3_d2", wr_data_q[2], 16'h0020);
        check("t3_d3", wr_data_q[3], 16'h0010);
        check("t3_d4", wr_data_q[4], 16'h0020);
        check("t3_c4", wr_cyc_q[4], s + 12);
        check("t3_ndone", done_cyc_q.size(), 0);
        check("t3_step_idx", step_idx, 1);

        // zero steps: control write only
        clear_logs();
        set_cfg(16'h1234, 16'h0001, 8'd0, 16'd3, 1'b0);
        pulse_start(s);
        repeat (8) @(negedge clk);
        check("t4_nwr", wr_addr_q.size(), 1);
        check("t4_a0", wr_addr_q[0], 16'h0030);
        check("t4_ndone", done_cyc_q.size(), 1);
        check("t4_done_cyc", done_cyc_q[0] - wr_cyc_q[0], 2);
        check("t4_busy", busy, 0);

        // start while busy with changed inputs is ignored
        clear_logs();
        set_cfg(16'h0002, 16'h0001, 8'd3, 16'd4, 1'b0);
        pulse_start(s);
        repeat (2) @(negedge clk);
        set_cfg(16'h0100, 16'h0100, 8'd5, 16'd0, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("t5a_nwr", wr_addr_q.size(), 4);
        check("t5a_d1", wr_data_q[1], 16'h0002);
        check("t5a_d3", wr_data_q[3], 16'h0004);
        check("t5a_ndone", done_cyc_q.size(), 1);

        // start and stop together in IDLE: nothing happens
        clear_logs();
        set_cfg(16'h0002, 16'h0001, 8'd3, 16'd4, 1'b0);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        repeat (8) @(negedge clk);
        check("t5b_nwr", wr_addr_q.size(), 0);
        check("t5b_busy", busy, 0);

        // stop sampled during the WR_FREQ cycle
        clear_logs();
        pulse_start(s);
        repeat (2) @(negedge clk);
        check("t5c_freq_wr", wr, 1);
        pulse_stop();
        check("t5c_busy", busy, 0);
        repeat (10) @(negedge clk);
        check("t5c_nwr", wr_addr_q.size(), 2);
        check("t5c_ndone", done_cyc_q.size(), 0);

        // asynchronous reset mid-sweep, then a fresh sweep
        clear_logs();
        pulse_start(s);
        repeat (7) @(negedge clk);
        check("t6_pre_wr", wr, 1);
        check("t6_pre_idx", step_idx, 1);
        #1;
        rstn = 1'b0;
        #1;
        check("t6_rst_wr", wr, 0);
        check("t6_rst_waddr", waddr, 0);
        check("t6_rst_wdata", wdata, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_idx", step_idx, 0);
        repeat (3) @(negedge clk);
        check("t6_rst_hold_wr", wr, 0);
        rstn = 1'b1;
        @(negedge clk);
        clear_logs();
        pulse_start(s);
        check("t6_new_wr", wr, 1);
        check("t6_new_addr", waddr, 16'h0030);
        check("t6_new_idx", step_idx, 0);
        repeat (2) @(negedge clk);
        check("t6_first_freq", wdata, 16'h0002);
        check("t6_first_idx", step_idx, 0);
        repeat (20) @(negedge clk);
        check("t6_nwr", wr_addr_q.size(), 4);
        check("t6_ndone", done_cyc_q.size(), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
